// File: rtl/multi_digit_view.sv
// rtl/multi_digit_view.sv - multi-digit seven-segment driver for chained 74HC595 shift registers
// Optional DIGIT_VIEW_HEX_EN: decode values 10..15 as hex glyphs instead of blanks.
module multi_digit_view #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  output logic                  ready,
  output logic                  done,
  output logic                  o_STCP,
  output logic                  o_SHCP,
  output logic                  o_DS
);

  localparam int NBITS = DIGITS * 8;
  localparam int BIT_W = $clog2(NBITS);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);
  localparam logic [DIV_W-1:0] HALF_END = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BIT_END  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DONE_AT  = DIV_W'(2 * CLK_DIV - 2);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t              state;
  logic [4*DIGITS-1:0] data_q;
  logic [DIGITS-1:0]   dp_q;
  logic [NBITS-1:0]    shreg;
  logic [NBITS-1:0]    decoded;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DIV_W-1:0]    div_cnt;

  function automatic logic [7:0] seg_decode(input logic [3:0] v, input logic pt);
    logic [7:0] s;
    case (v)
      4'd0:  s = 8'b00010001;
      4'd1:  s = 8'b11010111;
      4'd2:  s = 8'b00110010;
      4'd3:  s = 8'b10010010;
      4'd4:  s = 8'b11010100;
      4'd5:  s = 8'b10011000;
      4'd6:  s = 8'b00011000;
      4'd7:  s = 8'b11010011;
      4'd8:  s = 8'b00010000;
      4'd9:  s = 8'b10010000;
`ifdef DIGIT_VIEW_HEX_EN
      4'd10: s = 8'b01010000;
      4'd11: s = 8'b00011100;
      4'd12: s = 8'b00111001;
      4'd13: s = 8'b00010110;
      4'd14: s = 8'b00111000;
      default: s = 8'b01111000;
`else
      default: s = 8'b11111111;
`endif
    endcase
    if (pt) s[4] = 1'b0;
    return s;
  endfunction

  // Digit DIGITS-1 lands in the top byte so it leaves the chain first.
  always_comb begin
    decoded = '0;
    for (int k = 0; k < DIGITS; k++) begin
      decoded[8*k +: 8] = seg_decode(data_q[4*k +: 4], dp_q[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      dp_q    <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      o_STCP  <= 1'b0;
      o_SHCP  <= 1'b0;
      o_DS    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (write_en) begin
            data_q <= data;
            dp_q   <= dp;
            ready  <= 1'b0;
            state  <= LOAD;
          end
        end
        LOAD: begin
          shreg   <= decoded;
          o_DS    <= decoded[NBITS-1];
          o_SHCP  <= 1'b0;
          bit_cnt <= '0;
          div_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == HALF_END) o_SHCP <= 1'b1;
          if (div_cnt == BIT_END) begin
            o_SHCP  <= 1'b0;
            div_cnt <= '0;
            if (bit_cnt == LAST_BIT) begin
              o_DS   <= 1'b0;
              o_STCP <= 1'b1;
              state  <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              shreg   <= {shreg[NBITS-2:0], 1'b0};
              o_DS    <= shreg[NBITS-2];
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        LATCH: begin
          if (div_cnt == HALF_END) o_STCP <= 1'b0;
          // done is registered, so raise it one cycle ahead of the final LATCH cycle
          if (div_cnt == DONE_AT) done <= 1'b1;
          if (div_cnt == BIT_END) begin
            div_cnt <= '0;
            done    <= 1'b0;
            ready   <= 1'b1;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_digit_view.sv
// tb/tb_multi_digit_view.sv - scoreboard bench for multi_digit_view (DIGITS=4, CLK_DIV=2)
module tb_multi_digit_view;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 2;
  localparam int NBITS   = DIGITS * 8;
  localparam int BUSY    = 1 + 16 * DIGITS * CLK_DIV + 2 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic write_en = 1'b0;
  logic [4*DIGITS-1:0] data = '0;
  logic [DIGITS-1:0] dp = '0;
  logic ready, done, o_STCP, o_SHCP, o_DS;

  int checks = 0;
  int errors = 0;
  logic [NBITS-1:0] exp_q[$];

  int mon_bits = 0;
  int total_sh = 0;
  int total_st = 0;
  int done_cnt = 0;
  int since_sh = 0;
  logic [NBITS-1:0] word = '0;
  logic prev_sh = 1'b0, prev_st = 1'b0;

  multi_digit_view #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .data(data), .dp(dp),
    .ready(ready), .done(done), .o_STCP(o_STCP), .o_SHCP(o_SHCP), .o_DS(o_DS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference glyph table: active-low segments, dp bit (bit4) blank.
  function automatic logic [7:0] glyph(input int v, input bit pt);
    logic [7:0] tab [16];
    logic [7:0] g;
    tab = '{8'h11, 8'hD7, 8'h32, 8'h92, 8'hD4, 8'h98, 8'h18, 8'hD3, 8'h10, 8'h90,
`ifdef DIGIT_VIEW_HEX_EN
            8'h50, 8'h1C, 8'h39, 8'h16, 8'h38, 8'h78};
`else
            8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
    g = tab[v];
    if (pt) g = g & 8'hEF;
    return g;
  endfunction

  function automatic logic [NBITS-1:0] frame(input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] p);
    logic [NBITS-1:0] f = '0;
    for (int k = DIGITS - 1; k >= 0; k--) f = (f << 8) | NBITS'(glyph(int'((d >> (4 * k)) & 16'hF), p[k]));
    return f;
  endfunction

  // Monitor: reconstruct the shifted word from SHCP rises, score it at each STCP rise.
  always @(negedge clk) begin
    if (rst) begin
      mon_bits = 0;
      word = '0;
      prev_sh = 1'b0;
      prev_st = 1'b0;
    end else begin
      since_sh++;
      if (o_SHCP && !prev_sh) begin
        word = {word[NBITS-2:0], o_DS};
        mon_bits++;
        total_sh++;
        since_sh = 0;
      end
      if (o_STCP && !prev_st) begin
        total_st++;
        checks++;
        if (since_sh < CLK_DIV) begin
          errors++;
          $display("FAIL stcp_gap: got %0d expected >= %0d", since_sh, CLK_DIV);
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_latch: got latch of %h expected none", word);
        end else begin
          chk("frame_bits", 64'(mon_bits), 64'(NBITS));
          chk("frame_data", 64'(word), 64'(exp_q.pop_front()));
        end
        mon_bits = 0;
      end
      if (done) done_cnt++;
      prev_sh = o_SHCP;
      prev_st = o_STCP;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
  endtask

  // mode 0: plain frame, 1: write_en glitch mid-frame, 2: reset after ~10 SHCP rises
  task automatic send(input logic [15:0] d, input logic [3:0] p, input int mode);
    int busy, d0, s0;
    wait_ready();
    @(negedge clk);
    data = d; dp = p; write_en = 1'b1;
    if (mode != 2) exp_q.push_back(frame(d, p));
    @(negedge clk);
    write_en = 1'b0;
    d0 = done_cnt; s0 = total_st; busy = 0;
    while (!ready && busy < 2000) begin
      busy++;
      if (mode == 1 && busy == 40) begin
        write_en = 1'b1; data = 16'h9999; dp = 4'hF;
      end else if (mode == 1 && busy == 41) begin
        write_en = 1'b0;
      end
      if (mode == 2 && mon_bits >= 10) break;
      @(negedge clk);
    end
    if (mode == 2) begin
      #2 rst = 1'b1;
      #1;
      chk("abort_ready", 64'(ready), 64'd1);
      chk("abort_outs", 64'({o_STCP, o_SHCP, o_DS, done}), 64'd0);
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b0;
      repeat (200) @(negedge clk);
      chk("abort_no_latch", 64'(total_st - s0), 64'd0);
      chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    end else begin
      chk("busy_cycles", 64'(busy), 64'(BUSY));
      chk("done_pulses", 64'(done_cnt - d0), 64'd1);
      chk("latch_count", 64'(total_st - s0), 64'd1);
    end
  endtask

  // write_en held high across a whole frame: the next frame starts on the first ready cycle.
  task automatic back_to_back(input logic [15:0] a, input logic [15:0] b);
    int busy;
    wait_ready();
    @(negedge clk);
    data = a; dp = 4'h0; write_en = 1'b1;
    exp_q.push_back(frame(a, 4'h0));
    @(negedge clk);
    data = b;
    busy = 0;
    while (!ready && busy < 2000) begin
      busy++;
      @(negedge clk);
    end
    chk("b2b_busy1", 64'(busy), 64'(BUSY));
    exp_q.push_back(frame(b, 4'h0));
    @(negedge clk);
    write_en = 1'b0;
    busy = 0;
    while (!ready && busy < 2000) begin
      busy++;
      @(negedge clk);
    end
    chk("b2b_busy2", 64'(busy), 64'(BUSY));
  endtask

  initial begin
    int sh0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_outs", 64'({o_STCP, o_SHCP, o_DS, done}), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    sh0 = total_sh;
    repeat (200) @(negedge clk);
    chk("idle_no_shcp", 64'(total_sh - sh0), 64'd0);
    chk("idle_ready", 64'(ready), 64'd1);

    send(16'h4321, 4'b0000, 0);
    send(16'h0008, 4'b0001, 0);
    send(16'hFA00, 4'b0000, 0);
    send(16'h1234, 4'b0000, 1);
    send(16'h5678, 4'b1010, 2);
    send(16'h9876, 4'b0110, 0);
    back_to_back(16'h2468, 16'hBCDE);
    for (int i = 0; i < 16; i++) begin
      send(16'($urandom), 4'($urandom), int'($urandom_range(0, 1)));
    end
    repeat (20) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
